mlp_seq_engine: RTL

Parametrised, time-multiplexed two-layer perceptron: N_IN inputs → N_HID hidden neurons with ReLU → N_OUT outputs. It uses one shared signed MAC instead of fully parallel multipliers. It is the configurable successor to the fixed 4-4-2 dense/ReLU/dense datapath and adds valid/ready handshakes on both sides, output backpressure and optional saturation. It sits between the feature/weight loader and the result collector.

---
 rtl/mlp_seq_engine.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mlp_seq_engine.sv
`default_nettype none
// ============================================================================
// Module      : mlp_seq_engine
// Description : Time-multiplexed two-layer perceptron (dense/ReLU/dense) built
//               around one shared signed MAC, valid/ready on both sides.
//               Define MLP_SAT_EN to saturate stores instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_seq_engine #(
    parameter int N_IN  = 4,
    parameter int N_HID = 4,
    parameter int N_OUT = 2,
    parameter int DW    = 5,
    parameter int AW    = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N_IN*DW-1:0]        x_flat,
    input  logic [N_IN*N_HID*DW-1:0]  w1_flat,
    input  logic [N_HID*N_OUT*DW-1:0] w2_flat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [N_OUT*AW-1:0]       y_flat,
    output logic                      busy
);

    localparam int C_MAXIH = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int C_MAXN  = (C_MAXIH > N_OUT) ? C_MAXIH : N_OUT;
    localparam int C_CW    = $clog2(C_MAXN + 1);
    localparam int C_PW    = AW + DW;
    localparam int C_ACCW  = AW + DW + $clog2(C_MAXIH) + 1;

    localparam logic [C_CW-1:0] C_ONE       = C_CW'(1);
    localparam logic [C_CW-1:0] C_IN_LAST   = C_CW'(N_IN - 1);
    localparam logic [C_CW-1:0] C_HID_LAST  = C_CW'(N_HID - 1);
    localparam logic [C_CW-1:0] C_OUT_LAST  = C_CW'(N_OUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_L1   = 2'd1,
        S_L2   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                      r_state;
    logic [N_IN*DW-1:0]          r_x;
    logic [N_IN*N_HID*DW-1:0]    r_w1;
    logic [N_HID*N_OUT*DW-1:0]   r_w2;
    logic [N_HID*AW-1:0]         r_hid;
    logic [N_OUT*AW-1:0]         r_y;
    logic signed [C_ACCW-1:0]    r_acc;
    logic [C_CW-1:0]             r_fast;
    logic [C_CW-1:0]             r_slow;
    logic                        r_busy;
    logic                        r_out_valid;

    logic [31:0]                 w_fast_ix;
    logic [31:0]                 w_slow_ix;
    logic signed [DW-1:0]        w_x_sel;
    logic signed [DW-1:0]        w_w1_sel;
    logic signed [DW-1:0]        w_w2_sel;
    logic signed [AW-1:0]        w_h_sel;
    logic signed [AW-1:0]        w_a;
    logic signed [DW-1:0]        w_b;
    logic signed [C_PW-1:0]      w_prod;
    logic signed [C_ACCW-1:0]    w_sum;
    logic signed [AW-1:0]        w_fit;
    logic signed [AW-1:0]        w_relu;

    assign w_fast_ix = 32'(r_fast);
    assign w_slow_ix = 32'(r_slow);

    // Out-of-range selects only occur for the layer not currently active and are muxed away.
    assign w_x_sel  = r_x[w_fast_ix*DW +: DW];
    assign w_w1_sel = r_w1[(w_slow_ix*N_IN + w_fast_ix)*DW +: DW];
    assign w_h_sel  = r_hid[w_fast_ix*AW +: AW];
    assign w_w2_sel = r_w2[(w_slow_ix*N_HID + w_fast_ix)*DW +: DW];

    assign w_a    = (r_state == S_L2) ? w_h_sel : {{(AW-DW){w_x_sel[DW-1]}}, w_x_sel};
    assign w_b    = (r_state == S_L2) ? w_w2_sel : w_w1_sel;
    assign w_prod = w_a * w_b;
    assign w_sum  = r_acc + {{(C_ACCW-C_PW){w_prod[C_PW-1]}}, w_prod};

`ifdef MLP_SAT_EN
    localparam logic signed [C_ACCW-1:0] C_SAT_MAX = {{(C_ACCW-AW+1){1'b0}}, {(AW-1){1'b1}}};
    localparam logic signed [C_ACCW-1:0] C_SAT_MIN = {{(C_ACCW-AW+1){1'b1}}, {(AW-1){1'b0}}};

    always_comb begin
        w_fit = w_sum[AW-1:0];
        if (w_sum > C_SAT_MAX) begin
            w_fit = {1'b0, {(AW-1){1'b1}}};
        end else if (w_sum < C_SAT_MIN) begin
            w_fit = {1'b1, {(AW-1){1'b0}}};
        end
    end
`else
    assign w_fit = w_sum[AW-1:0];
`endif

    assign w_relu = w_fit[AW-1] ? '0 : w_fit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_x         <= '0;
            r_w1        <= '0;
            r_w2        <= '0;
            r_hid       <= '0;
            r_y         <= '0;
            r_acc       <= '0;
            r_fast      <= '0;
            r_slow      <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_x     <= x_flat;
                        r_w1    <= w1_flat;
                        r_w2    <= w2_flat;
                        r_acc   <= '0;
                        r_fast  <= '0;
                        r_slow  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_L1;
                    end
                end
                S_L1: begin
                    if (r_fast == C_IN_LAST) begin
                        r_hid[w_slow_ix*AW +: AW] <= w_relu;
                        r_acc  <= '0;
                        r_fast <= '0;
                        if (r_slow == C_HID_LAST) begin
                            r_slow  <= '0;
                            r_state <= S_L2;
                        end else begin
                            r_slow <= r_slow + C_ONE;
                        end
                    end else begin
                        r_acc  <= w_sum;
                        r_fast <= r_fast + C_ONE;
                    end
                end
                S_L2: begin
                    if (r_fast == C_HID_LAST) begin
                        r_y[w_slow_ix*AW +: AW] <= w_fit;
                        r_acc  <= '0;
                        r_fast <= '0;
                        if (r_slow == C_OUT_LAST) begin
                            r_slow      <= '0;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_slow <= r_slow + C_ONE;
                        end
                    end else begin
                        r_acc  <= w_sum;
                        r_fast <= r_fast + C_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by rst so no job can be offered acceptance during the reset cycle.
    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign y_flat    = r_y;
    assign busy      = r_busy;

endmodule
`default_nettype wire
